// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and helpers for the shared iterative divider
package div_pkg;

    typedef enum logic [1:0] {IDLE, ITER, FIX} div_state_t;

    localparam int DIV_N_DEFAULT = 32;
    localparam int DIV_MAX_W     = 64;

    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Negate in one extra bit so the magnitude of the most negative value stays exact.
    function automatic logic [DIV_MAX_W:0] abs_ext(input logic [DIV_MAX_W-1:0] v, input logic neg);
        return neg ? (~{1'b0, v} + (DIV_MAX_W+1)'(1)) : {1'b0, v};
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// rtl/div_iter_core.sv - unsigned restoring divider, one quotient bit per cycle, MSB first
module div_iter_core #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_q,
`ifdef DIV_ARB_REM_EN
    output logic [N-1:0] o_r,
`endif
    output logic         o_last
);
    localparam int CNT_W = $clog2(N);

    logic [N-1:0]     r_q;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;

    logic [N:0] w_shift;
    logic [N:0] w_diff;
    logic       w_ge;

    // The remainder stays below |b| <= 2^(N-1), so N bits hold it and N+1 hold the shift.
    assign w_shift = {r_rem, r_q[N-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_ge    = ~w_diff[N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_q      <= i_a;
            r_b      <= i_b;
            r_rem    <= '0;
            r_cnt    <= CNT_W'(N-1);
            r_active <= 1'b1;
        end else if (r_active) begin
            r_rem <= w_ge ? w_diff[N-1:0] : w_shift[N-1:0];
            r_q   <= {r_q[N-2:0], w_ge};
            if (r_cnt == '0) r_active <= 1'b0;
            else             r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

    assign o_q    = r_q;
    assign o_last = r_active && (r_cnt == '0);
`ifdef DIV_ARB_REM_EN
    assign o_r    = r_rem;
`endif

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one signed iterative divider
// Optional remainder output enabled by DIV_ARB_REM_EN.
module div_arbiter
    import div_pkg::*;
#(
    parameter int  N    = DIV_N_DEFAULT,
    parameter int  NREQ = 4,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] a_flat,
    input  logic [NREQ*N-1:0] b_flat,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [N-1:0]      res,
    output logic [ID_W-1:0]   res_id,
    output logic              res_valid,
    output logic              dbz,
`ifdef DIV_ARB_REM_EN
    output logic [N-1:0]      rem,
`endif
    output logic              ovf
);
    localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

    div_state_t      r_state;
    logic [ID_W-1:0] r_rr, r_id, r_res_id;
    logic [NREQ-1:0] r_gnt;
    logic [N-1:0]    r_res;
    logic            r_busy, r_res_valid, r_dbz, r_ovf, r_sign, r_dbz_p, r_ovf_p;
`ifdef DIV_ARB_REM_EN
    logic [N-1:0]    r_rem;
    logic            r_sign_a;
    logic [N-1:0]    w_r;
`endif

    logic            w_found, w_special, w_start, w_last;
    logic [ID_W-1:0] w_gid, w_rr_next;
    logic [N-1:0]    w_a, w_b, w_abs_a, w_abs_b, w_q;

    // Scan from the highest offset down so the lowest offset from the pointer wins.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_gid   = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            idx = int'(r_rr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                w_found = 1'b1;
                w_gid   = ID_W'(idx);
            end
        end
    end

    assign w_rr_next = (w_gid == ID_W'(NREQ-1)) ? '0 : w_gid + ID_W'(1);
    assign w_a       = a_flat[w_gid*N +: N];
    assign w_b       = b_flat[w_gid*N +: N];
    assign w_abs_a   = N'(abs_ext(DIV_MAX_W'(w_a), w_a[N-1]));
    assign w_abs_b   = N'(abs_ext(DIV_MAX_W'(w_b), w_b[N-1]));
    assign w_special = (w_b == '0) || ((w_a == MIN_V) && (w_b == '1));
    assign w_start   = (r_state == IDLE) && w_found && !w_special;

    div_iter_core #(.N(N)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_a     (w_abs_a),
        .i_b     (w_abs_b),
        .o_q     (w_q),
`ifdef DIV_ARB_REM_EN
        .o_r     (w_r),
`endif
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr        <= '0;
            r_id        <= '0;
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_res       <= '0;
            r_res_id    <= '0;
            r_res_valid <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            r_sign      <= 1'b0;
            r_dbz_p     <= 1'b0;
            r_ovf_p     <= 1'b0;
`ifdef DIV_ARB_REM_EN
            r_rem       <= '0;
            r_sign_a    <= 1'b0;
`endif
        end else begin
            r_gnt       <= '0;
            r_res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= w_found;
                    if (w_found) begin
                        r_gnt   <= NREQ'(1) << w_gid;
                        r_id    <= w_gid;
                        r_rr    <= w_rr_next;
                        r_sign  <= w_a[N-1] ^ w_b[N-1];
                        r_dbz_p <= (w_b == '0);
                        r_ovf_p <= (w_b != '0) && w_special;
`ifdef DIV_ARB_REM_EN
                        r_sign_a <= w_a[N-1];
`endif
                        r_state <= w_special ? FIX : ITER;
                    end
                end
                ITER: begin
                    if (w_last) r_state <= FIX;
                end
                FIX: begin
                    r_res_valid <= 1'b1;
                    r_res_id    <= r_id;
                    r_dbz       <= r_dbz_p;
                    r_ovf       <= r_ovf_p;
                    r_res       <= r_dbz_p ? '0 : (r_ovf_p ? MIN_V : (r_sign ? -w_q : w_q));
`ifdef DIV_ARB_REM_EN
                    r_rem       <= (r_dbz_p || r_ovf_p) ? '0 : (r_sign_a ? -w_r : w_r);
`endif
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign res       = r_res;
    assign res_id    = r_res_id;
    assign res_valid = r_res_valid;
    assign dbz       = r_dbz;
    assign ovf       = r_ovf;
`ifdef DIV_ARB_REM_EN
    assign rem       = r_rem;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed self-checking bench for div_arbiter (N=32, NREQ=4)
module tb_div_arbiter;

    localparam int N    = 32;
    localparam int LAT  = N + 1;
    localparam logic [31:0] MIN_V = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] a_flat = '0;
    logic [127:0] b_flat = '0;
    logic [3:0]   gnt;
    logic         busy;
    logic [31:0]  res;
    logic [1:0]   res_id;
    logic         res_valid;
    logic         dbz;
    logic         ovf;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    div_arbiter #(.N(N), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .gnt       (gnt),
        .busy      (busy),
        .res       (res),
        .res_id    (res_id),
        .res_valid (res_valid),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          output logic [3:0] g, output logic [31:0] r, output logic [1:0] rid,
                          output logic dz, output logic ov, output int lat,
                          output logic bz_g, output logic to);
        int gc;
        to = 1'b0; g = '0; r = 'x; rid = 'x; dz = 'x; ov = 'x; lat = -1; bz_g = 1'b0;
        @(negedge clk);
        a_flat[id*32 +: 32] = a;
        b_flat[id*32 +: 32] = b;
        req[id] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt != '0) break;
        end
        g = gnt; bz_g = busy; gc = cyc;
        req[id] = 1'b0;
        if (g == '0) begin to = 1'b1; return; end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        if (!res_valid) begin to = 1'b1; return; end
        lat = cyc - gc; r = res; rid = res_id; dz = dbz; ov = ovf;
    endtask

    task automatic test_reset();
        n_chk++;
        if ({gnt, busy, res, res_id, res_valid, dbz, ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got gnt=%b busy=%b res=%h id=%0d v=%b dbz=%b ovf=%b exp all 0",
                     gnt, busy, res, res_id, res_valid, dbz, ovf);
        end
    endtask

    task automatic test_basic();
        logic [3:0] g; logic [31:0] r; logic [1:0] rid; logic dz, ov, bz, to; int lat;
        run_op(0, 32'd100, 32'd7, g, r, rid, dz, ov, lat, bz, to);
        n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b exp 0", to); end
        n_chk++; if (g !== 4'b0001) begin n_fail++; $display("FAIL basic_gnt got %b exp 0001", g); end
        n_chk++; if (bz !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_grant got %b exp 1", bz); end
        n_chk++; if (r !== 32'd14) begin n_fail++; $display("FAIL basic_res got %0d exp 14", $signed(r)); end
        n_chk++; if (rid !== 2'd0) begin n_fail++; $display("FAIL basic_res_id got %0d exp 0", rid); end
        n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", lat, LAT); end
        n_chk++; if ({dz, ov} !== 2'b00) begin n_fail++; $display("FAIL basic_flags got %b exp 00", {dz, ov}); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_valid got %b exp 1", busy); end
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b exp 0", busy); end
        repeat (3) @(negedge clk);
        n_chk++; if ({res_valid, res} !== {1'b0, 32'd14}) begin
            n_fail++; $display("FAIL basic_hold got v=%b res=%0d exp v=0 res=14", res_valid, $signed(res));
        end
    endtask

    task automatic test_signs();
        logic [31:0] va [10] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FF9C,
                                 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'h8000_0000};
        logic [31:0] vb [10] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd2, 32'd7,
                                 32'd1, 32'd1, 32'd2, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] ve [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3, 32'd3, 32'hFFFF_FFF2,
                                 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'd0, 32'd1};
        logic [3:0] g; logic [31:0] r; logic [1:0] rid; logic dz, ov, bz, to; int lat;
        for (int i = 0; i < 10; i++) begin
            run_op(1, va[i], vb[i], g, r, rid, dz, ov, lat, bz, to);
            n_chk++;
            if ({to, r, rid, dz, ov} !== {1'b0, ve[i], 2'd1, 2'b00} || lat !== LAT) begin
                n_fail++;
                $display("FAIL signs_%0d got res=%0d id=%0d dbz=%b ovf=%b lat=%0d to=%b exp res=%0d id=1 flags=00 lat=%0d",
                         i, $signed(r), rid, dz, ov, lat, to, $signed(ve[i]), LAT);
            end
        end
    endtask

    task automatic test_special();
        logic [3:0] g; logic [31:0] r; logic [1:0] rid; logic dz, ov, bz, to; int lat;
        run_op(2, 32'd5, 32'd0, g, r, rid, dz, ov, lat, bz, to);
        n_chk++;
        if ({to, r, rid, dz, ov} !== {1'b0, 32'd0, 2'd2, 2'b10} || lat !== 1) begin
            n_fail++;
            $display("FAIL dbz_case got res=%h id=%0d dbz=%b ovf=%b lat=%0d exp res=0 id=2 dbz=1 ovf=0 lat=1", r, rid, dz, ov, lat);
        end
        run_op(0, MIN_V, 32'hFFFF_FFFF, g, r, rid, dz, ov, lat, bz, to);
        n_chk++;
        if ({to, r, rid, dz, ov} !== {1'b0, MIN_V, 2'd0, 2'b01} || lat !== 1) begin
            n_fail++;
            $display("FAIL ovf_case got res=%h id=%0d dbz=%b ovf=%b lat=%0d exp res=80000000 id=0 dbz=0 ovf=1 lat=1", r, rid, dz, ov, lat);
        end
        run_op(3, 32'hFFFF_FFFB, 32'd0, g, r, rid, dz, ov, lat, bz, to);
        n_chk++;
        if ({to, r, rid, dz, ov} !== {1'b0, 32'd0, 2'd3, 2'b10}) begin
            n_fail++;
            $display("FAIL dbz_neg got res=%h id=%0d dbz=%b ovf=%b exp res=0 id=3 dbz=1 ovf=0", r, rid, dz, ov);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] g; logic [31:0] r; logic [1:0] rid; logic dz, ov, bz, to; int lat; int nv;
        @(negedge clk);
        a_flat[2*32 +: 32] = 32'd1000; b_flat[2*32 +: 32] = 32'd3; req[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin @(negedge clk); if (gnt != '0) break; end
        req[2] = 1'b0;
        repeat (10) @(negedge clk);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({gnt, busy, res, res_id, res_valid, dbz, ovf} !== '0) begin
            n_fail++;
            $display("FAIL midreset_async got busy=%b res=%h id=%0d v=%b dbz=%b ovf=%b exp all 0", busy, res, res_id, res_valid, dbz, ovf);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 40; k++) begin @(negedge clk); if (res_valid) nv++; end
        n_chk++; if (nv !== 0) begin n_fail++; $display("FAIL midreset_no_valid got %0d pulses exp 0", nv); end
        run_op(3, 32'd50, 32'd5, g, r, rid, dz, ov, lat, bz, to);
        n_chk++;
        if ({to, g, r, rid} !== {1'b0, 4'b1000, 32'd10, 2'd3}) begin
            n_fail++; $display("FAIL midreset_next got to=%b gnt=%b res=%0d id=%0d exp gnt=1000 res=10 id=3", to, g, r, rid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] gv [5];
        int gc [5];
        int ng = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            a_flat[i*32 +: 32] = 32'(100 * (i + 1));
            b_flat[i*32 +: 32] = 32'(i + 2);
        end
        req = 4'b1111;
        for (int t = 0; t < 300 && ng < 5; t++) begin
            @(negedge clk);
            if (gnt != '0) begin
                gv[ng] = gnt; gc[ng] = cyc; ng++;
                if (ng == 5) req = '0;
            end
        end
        req = '0;
        n_chk++; if (ng !== 5) begin n_fail++; $display("FAIL rr_count got %0d grants exp 5", ng); end
        for (int k = 0; k < ng; k++) begin
            n_chk++;
            if (gv[k] !== 4'(1 << (k % 4))) begin
                n_fail++; $display("FAIL rr_order_%0d got %b exp %b", k, gv[k], 4'(1 << (k % 4)));
            end
            if (k > 0) begin
                n_chk++;
                if (gc[k] - gc[k-1] !== N + 2) begin
                    n_fail++; $display("FAIL rr_gap_%0d got %0d exp %0d", k, gc[k] - gc[k-1], N + 2);
                end
            end
        end
        for (int k = 0; k < 60; k++) begin @(negedge clk); if (res_valid) break; end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] g; logic [31:0] r; logic [1:0] rid; logic dz, ov, bz, to; int lat;
        logic [31:0] a, b;
        logic signed [31:0] e;
        for (int i = 0; i < 120; i++) begin
            if (i % 2 == 0) begin
                a = $urandom; b = $urandom;
            end else begin
                a = $urandom_range(0, 2000); b = $urandom_range(1, 50);
                if ($urandom_range(0, 1) == 1) a = -a;
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            if (b == '0) b = 32'd1;
            if (a == MIN_V && b == 32'hFFFF_FFFF) b = 32'd3;
            e = $signed(a) / $signed(b);
            run_op(i % 4, a, b, g, r, rid, dz, ov, lat, bz, to);
            n_chk++;
            if ({to, r, rid} !== {1'b0, e, 2'(i % 4)}) begin
                n_fail++;
                $display("FAIL random_%0d a=%0d b=%0d got res=%0d id=%0d to=%b exp res=%0d id=%0d",
                         i, $signed(a), $signed(b), $signed(r), rid, to, e, i % 4);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_signs();
        test_special();
        test_reset_mid();
        test_round_robin();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
